counter_sequencer: RTL
======================

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed as name, direction, width, meaning.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 rst_n  input  1  Asynchronous active-low reset.
REQ-004 start  input  1  Request a count run; sampled only in IDLE.
REQ-005 abort  input  1  Terminate the run; sampled in LOAD, RUN and DONE.
REQ-006 ack  input  1  Acknowledge completion; sampled in DONE.
REQ-007 base_value  input  8  Start value, latched when start is accepted.
REQ-008 end_value  input  8  Terminal value, latched when start is accepted.
REQ-009 cnt_state  input  8  Read-back of the 8-bit sync counter output.
REQ-010 cnt_rst  output  1  Synchronous reset to the counter.
REQ-011 cnt_load  output  1  Load strobe to the counter.
REQ-012 cnt_out_en  output  1  Output enable to the counter.
REQ-013 cnt_base  output  8  Load value to the counter, equal to the latched base or end.
REQ-014 busy  output  1  High in LOAD and RUN.
REQ-015 done  output  1  High in DONE.
REQ-016 run_len  output  8  Number of RUN cycles in the last completed run, modulo 256.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, RUN and DONE, with registered state and combinational outputs.
REQ-018 IDLE: cnt_rst=1, cnt_load=0, cnt_out_en=0; start=1 SHALL latch base/end and go to LOAD.
REQ-019 LOAD (exactly 1 cycle): cnt_load=1, cnt_base=latched base; next state RUN.
REQ-020 RUN: cnt_out_en=1; match=(cnt_state==latched end); the RUN cycle counter SHALL increment every RUN cycle, starting from 1 on the first RUN cycle.
REQ-021 RUN with match: cnt_load=1 and cnt_base=latched end in the same cycle, so the counter holds end; run_len SHALL take the RUN cycle count; next state DONE.
REQ-022 DONE: cnt_load=1, cnt_base=latched end, cnt_out_en=1, done=1; ack=1 SHALL go to IDLE.
REQ-023 Latency: start is accepted in cycle 0, LOAD is cycle 1, and the first RUN cycle is cycle 2 with cnt_state=base.
REQ-024 Wrap-around: end<base SHALL count through 255->0; run_len=((end-base) mod 256)+1.
REQ-025 base==end: match SHALL occur in the first RUN cycle, with run_len=1 and DONE in cycle 3.
REQ-026 run_len=256 (base=end+1) SHALL report 0.
REQ-027 abort SHALL take priority over match and ack: next state IDLE, run_len unchanged, done not asserted.
REQ-028 start outside IDLE, ack outside DONE and abort in IDLE SHALL be ignored.
REQ-029 cnt_rst, cnt_load and cnt_out_en SHALL never permit rst and load to be asserted together.

Reset
REQ-030 On rst_n=0, regardless of clk, the block SHALL enter IDLE with latched base/end=0, run_len=0 and the RUN cycle counter=0.
REQ-031 During reset, outputs SHALL be busy=0, done=0, cnt_rst=1, cnt_load=0, cnt_out_en=0 and cnt_base=0.
REQ-032 Reset asserted mid-run SHALL abandon the run immediately with no done pulse.

Configuration
REQ-033 Macro COUNTER_SEQUENCER_PERIODIC_EN SHALL add an input periodic (1 bit) and an output period_cnt (8 bits, reset 0).
REQ-034 With the macro defined and periodic=1, a match in RUN SHALL go to LOAD instead of DONE and increment period_cnt, saturating at 255.
REQ-035 With the macro defined, the periodic loop SHALL exit only through abort or reset, and period_cnt SHALL clear on start acceptance.
REQ-036 Without the macro, periodic and period_cnt SHALL be absent and behaviour SHALL be exactly REQ-017..REQ-032.

Verification
REQ-037 Base run: base=3, end=7, start pulse -> LOAD in cycle 1, cnt_state 3..7 in cycles 2..6, done from cycle 7, run_len=5, counter held at 7 until ack.
REQ-038 Wrap: base=250, end=4 -> run_len=11, cnt_state sequence 250..255,0..4.
REQ-039 Equal and maximum: base=end=9 -> done in cycle 3, run_len=1; base=10, end=9 -> run_len=0 after 256 RUN cycles.
REQ-040 Abort: abort in the 3rd RUN cycle -> IDLE next cycle, cnt_rst=1, done never high, run_len retains its prior value.
REQ-041 Reset and ignored inputs: rst_n low mid-RUN -> immediate IDLE outputs; start during RUN and ack in IDLE -> no effect.
REQ-042 Periodic (macro defined): base=0, end=2, periodic=1 -> LOAD every 4 cycles, period_cnt 1, 2, 3, ..., saturating at 255.

Source files
------------

// File: rtl/counter_sequencer.sv
// Sequencer for an external 8-bit counter: load base, run to end, report the run length.
// Optional COUNTER_SEQUENCER_PERIODIC_EN adds a periodic reload loop with a period counter.
module counter_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       ack,
  input  logic [7:0] base_value,
  input  logic [7:0] end_value,
  input  logic [7:0] cnt_state,
`ifdef COUNTER_SEQUENCER_PERIODIC_EN
  input  logic       periodic,
  output logic [7:0] period_cnt,
`endif
  output logic       cnt_rst,
  output logic       cnt_load,
  output logic       cnt_out_en,
  output logic [7:0] cnt_base,
  output logic       busy,
  output logic       done,
  output logic [7:0] run_len
);

  // state | meaning
  // IDLE  | counter held in reset, waiting for start
  // LOAD  | one cycle, counter loads the latched base
  // RUN   | counter enabled, watching for cnt_state == latched end
  // DONE  | counter held at end until ack
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t     state;
  logic [7:0] base_q;
  logic [7:0] end_q;
  logic [7:0] run_cnt;
  logic [7:0] run_cnt_nxt;
  logic       match;

  assign match       = (state == RUN) && (cnt_state == end_q);
  assign run_cnt_nxt = run_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base_q  <= 8'd0;
      end_q   <= 8'd0;
      run_cnt <= 8'd0;
      run_len <= 8'd0;
`ifdef COUNTER_SEQUENCER_PERIODIC_EN
      period_cnt <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_value;
            end_q  <= end_value;
            state  <= LOAD;
`ifdef COUNTER_SEQUENCER_PERIODIC_EN
            period_cnt <= 8'd0;
`endif
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            run_cnt <= 8'd0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            run_cnt <= run_cnt_nxt;
            if (match) begin
              // a 256-cycle run wraps the count to 0 by design
              run_len <= run_cnt_nxt;
`ifdef COUNTER_SEQUENCER_PERIODIC_EN
              if (periodic) begin
                state <= LOAD;
                if (period_cnt != 8'hFF) period_cnt <= period_cnt + 8'd1;
              end else begin
                state <= DONE;
              end
`else
              state <= DONE;
`endif
            end
          end
        end
        DONE: begin
          if (abort || ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // the counter loads end on the match cycle so it parks there through DONE
  assign cnt_base = ((state == DONE) || match) ? end_q : base_q;

  always_comb begin
    cnt_rst    = 1'b0;
    cnt_load   = 1'b0;
    cnt_out_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: cnt_rst = 1'b1;
      LOAD: begin
        cnt_load = 1'b1;
        busy     = 1'b1;
      end
      RUN: begin
        cnt_out_en = 1'b1;
        cnt_load   = match;
        busy       = 1'b1;
      end
      DONE: begin
        cnt_load   = 1'b1;
        cnt_out_en = 1'b1;
        done       = 1'b1;
      end
      default: cnt_rst = 1'b1;
    endcase
  end

endmodule
